// File: rtl/sdm_rr_scheduler_pkg.sv
// rtl/sdm_rr_scheduler_pkg.sv - fixed-point and channel-index helpers
//
// Purpose: constant functions shared by the sdm family and the shared-resource
//          schedulers. No ports.
//   fx_frac      : fractional bits of a signed Q(INT_WIDTH).(FRAC) word
//   fx_one       : +1.0 in that format
//   fx_minus_one : -1.0 in that format
//   ch_width     : index width for n channels (never below 1)
package sdm_rr_scheduler_pkg;

  function automatic int fx_frac(input int bit_width, input int int_width);
    return bit_width - int_width - 1;
  endfunction

  function automatic longint fx_one(input int bit_width, input int int_width);
    return longint'(1) << fx_frac(bit_width, int_width);
  endfunction

  function automatic longint fx_minus_one(input int bit_width, input int int_width);
    return -fx_one(bit_width, int_width);
  endfunction

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdm_rr_scheduler_rr_arbiter.sv
// rtl/sdm_rr_scheduler_rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: grants the first asserted request at or after ptr, searching upward
//          and wrapping from N-1 to 0. The pointer itself is owned by the caller.
// Ports:
//   req   in  N  request vector
//   ptr   in  W  highest-priority index this cycle
//   grant out N  one-hot grant, all zero when req is zero
//   idx   out W  encoded index of the granted request (0 when none)
module rr_arbiter
  import sdm_rr_scheduler_pkg::*;
#(
  parameter int N = 4,
  parameter int W = ch_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);

  logic         found;
  logic [W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      // Candidate k places after the pointer, modulo N so non power-of-two
      // channel counts wrap correctly.
      cand = W'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/sdm_rr_scheduler.sv
// rtl/sdm_rr_scheduler.sv - round-robin time-multiplexed sigma-delta modulator
//
// Purpose: one first-order SDM datapath shared across N_CH channels, each with
//          its own error accumulator. One channel is served per cycle and its
//          bit is emitted one cycle later tagged with the channel index.
// Ports:
//   CLK       in  1             clock, rising edge
//   RST       in  1             asynchronous active-high reset
//   req       in  N_CH          per-channel request, held until granted
//   x         in  N_CH*BIT_WIDTH packed signed samples, ch i at [i*BIT_WIDTH +: BIT_WIDTH]
//   clr       in  N_CH          per-channel synchronous clear of the error accumulator
//   grant     out N_CH          one-hot combinational accept strobe
//   out_valid out 1             registered, out_ch/out_y valid
//   out_ch    out CH_W          registered channel of the emitted bit
//   out_y     out 1             registered SDM output bit
module sdm_rr_scheduler
  import sdm_rr_scheduler_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int INT_WIDTH = 1,
  parameter int N_CH      = 4,
  parameter int CH_W      = ch_width(N_CH)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_CH-1:0]           req,
  input  logic [N_CH*BIT_WIDTH-1:0] x,
  input  logic [N_CH-1:0]           clr,
  output logic [N_CH-1:0]           grant,
  output logic                      out_valid,
  output logic [CH_W-1:0]           out_ch,
  output logic                      out_y
);

  localparam logic signed [BIT_WIDTH-1:0] ONE       = BIT_WIDTH'(fx_one(BIT_WIDTH, INT_WIDTH));
  localparam logic signed [BIT_WIDTH-1:0] MINUS_ONE = BIT_WIDTH'(fx_minus_one(BIT_WIDTH, INT_WIDTH));

  logic signed [BIT_WIDTH-1:0] err_q [N_CH];
  logic signed [BIT_WIDTH-1:0] x_arr [N_CH];
  logic [CH_W-1:0]             ptr_q;
  logic [CH_W-1:0]             gidx;
  logic                        any_grant;

  logic signed [BIT_WIDTH-1:0] x_g;
  logic signed [BIT_WIDTH-1:0] err_g;
  logic signed [BIT_WIDTH-1:0] y_new;
  logic signed [BIT_WIDTH-1:0] err_next;
  logic                        y;

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign x_arr[i] = x[i*BIT_WIDTH +: BIT_WIDTH];
  end

  rr_arbiter #(
    .N (N_CH),
    .W (CH_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gidx)
  );

  assign any_grant = |grant;

  // Shared SDM step on the granted channel. When nothing is granted the
  // result is computed for channel 0 but never committed.
  assign x_g      = x_arr[gidx];
  assign err_g    = err_q[gidx];
  assign y        = (x_g >= err_g);
  assign y_new    = y ? ONE : MINUS_ONE;
  assign err_next = y_new - x_g + err_g;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_CH; i++) begin
        err_q[i] <= '0;
      end
      ptr_q     <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_y     <= 1'b0;
    end else begin
      // Clear wins over the update, but the emitted bit below was already
      // formed from the pre-clear error.
      for (int i = 0; i < N_CH; i++) begin
        if (clr[i]) begin
          err_q[i] <= '0;
        end else if (any_grant && (gidx == CH_W'(i))) begin
          err_q[i] <= err_next;
        end
      end

      if (any_grant) begin
        ptr_q  <= (gidx == CH_W'(N_CH - 1)) ? '0 : gidx + 1'b1;
        out_ch <= gidx;
        out_y  <= y;
      end
      out_valid <= any_grant;
    end
  end

endmodule

// File: tb/tb_sdm_rr_scheduler.sv
// tb/tb_sdm_rr_scheduler.sv - directed self-checking bench for sdm_rr_scheduler
module tb_sdm_rr_scheduler;

  logic        CLK;
  logic        RST;
  logic [3:0]  req;
  logic [63:0] x;
  logic [3:0]  clr;
  logic [3:0]  grant;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic        out_y;

  int    checks   = 0;
  int    failures = 0;
  string phase    = "reset";

  // Hand-derived bit/error sequences from a zero error accumulator.
  // x=+0.5 (0x2000): err 2000,4000,E000,0000 ; bits 1,1,0,1
  // x=-0.5 (0xE000): err E000,4000,2000,0000 ; bits 0,1,0,0
  logic        y0_seq [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic        y1_seq [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [15:0] e0_seq [4] = '{16'h2000, 16'h4000, 16'hE000, 16'h0000};

  sdm_rr_scheduler #(
    .BIT_WIDTH (16),
    .INT_WIDTH (1),
    .N_CH      (4),
    .CH_W      (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req),
    .x         (x),
    .clr       (clr),
    .grant     (grant),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_y     (out_y)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog phase=%s", phase);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s/%s got=0x%0h want=0x%0h", phase, tag, got, want);
    end
  endtask

  task automatic set_x(input int ch, input logic [15:0] v);
    x[ch*16 +: 16] = v;
  endtask

  // Drive req/clr, check the combinational grant, clock once, check the
  // registered output. g < 0 means no grant is expected.
  task automatic cycle(input logic [3:0] r, input logic [3:0] c, input int g, input logic yexp);
    req = r;
    clr = c;
    #1;
    check("grant", {28'h0, grant}, (g < 0) ? 32'h0 : (32'h1 << g));
    @(posedge CLK);
    #1;
    clr = '0;
    check("out_valid", {31'h0, out_valid}, (g < 0) ? 32'h0 : 32'h1);
    if (g >= 0) begin
      check("out_ch", {30'h0, out_ch}, g);
      check("out_y", {31'h0, out_y}, {31'h0, yexp});
    end
  endtask

  task automatic check_err(input int ch, input logic [15:0] want);
    check($sformatf("err%0d", ch), {16'h0, dut.err_q[ch]}, {16'h0, want});
  endtask

  task automatic four_ch_run(input int n);
    for (int k = 0; k < n; k++) begin
      int g;
      int j;
      logic ye;
      g = k % 4;
      j = (k / 4) % 4;
      case (g)
        0:       ye = y0_seq[j];
        1:       ye = y1_seq[j];
        2:       ye = 1'b0;
        default: ye = 1'b1;
      endcase
      cycle(4'b1111, 4'b0000, g, ye);
    end
  endtask

  initial begin
    RST = 1'b1;
    req = '0;
    clr = '0;
    x   = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("out_valid", {31'h0, out_valid}, 32'h0);
    check("out_ch", {30'h0, out_ch}, 32'h0);
    check("out_y", {31'h0, out_y}, 32'h0);
    check("grant_idle", {28'h0, grant}, 32'h0);
    for (int i = 0; i < 4; i++) check_err(i, 16'h0000);
    RST = 1'b0;

    // Single channel at +0.5
    phase = "ch0_half";
    set_x(0, 16'h2000);
    for (int k = 0; k < 8; k++) begin
      cycle(4'b0001, 4'b0000, 0, y0_seq[k % 4]);
      check_err(0, e0_seq[k % 4]);
    end

    // No request: valid drops, ch/y hold
    phase = "idle_hold";
    cycle(4'b0000, 4'b0000, -1, 1'b0);
    check("out_ch_hold", {30'h0, out_ch}, 32'h0);
    check("out_y_hold", {31'h0, out_y}, 32'h1);

    // Clear together with a grant: bit uses pre-clear error
    phase = "clr_grant";
    cycle(4'b0001, 4'b0000, 0, 1'b1);
    cycle(4'b0001, 4'b0000, 0, 1'b1);
    check_err(0, 16'h4000);
    cycle(4'b0001, 4'b0001, 0, 1'b0);
    check_err(0, 16'h0000);
    cycle(4'b0001, 4'b0000, 0, 1'b1);
    check_err(0, 16'h2000);

    // Full-scale inputs on ch2 (ptr is 1, so ch2 is found by search)
    phase = "ch2_fullscale";
    set_x(2, 16'hC000);
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0100, 4'b0000, 2, 1'b0);
      check_err(2, 16'h0000);
    end
    set_x(2, 16'h4000);
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0100, 4'b0000, 2, 1'b1);
      check_err(2, 16'h0000);
    end

    // Simultaneous clear of all channels without any grant
    phase = "clr_all";
    cycle(4'b0000, 4'b1111, -1, 1'b0);
    for (int i = 0; i < 4; i++) check_err(i, 16'h0000);

    // Two channels interleaved; ptr is 3 so ch0 wins first
    phase = "two_ch";
    set_x(0, 16'h2000);
    set_x(1, 16'hE000);
    for (int k = 0; k < 8; k++) begin
      cycle(4'b0011, 4'b0000, k % 2, (k % 2 == 0) ? y0_seq[k / 2] : y1_seq[k / 2]);
    end

    // Async reset between edges while out_valid is high
    phase = "rst_async_a";
    #2;
    RST = 1'b1;
    #1;
    check("out_valid_async", {31'h0, out_valid}, 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Four channels, grant order 0,1,2,3
    phase = "four_ch";
    set_x(2, 16'hC000);
    set_x(3, 16'h4000);
    four_ch_run(6);

    phase = "rst_async_b";
    #2;
    RST = 1'b1;
    #1;
    check("out_valid_async", {31'h0, out_valid}, 32'h0);
    check("out_ch_async", {30'h0, out_ch}, 32'h0);
    check("out_y_async", {31'h0, out_y}, 32'h0);
    check_err(0, 16'h0000);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    phase = "four_ch_after_rst";
    four_ch_run(8);

    req = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
